// File: rtl/rr_arb_mux_pkg.sv
// Shared types and reset constants for the rr_arb_mux slice.
// The burst-lock FSM state type is only used when RR_ARB_MUX_LOCK_EN is defined.
package rr_arb_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic   RST_OUT_VALID = 1'b0;
    localparam logic   RST_OUT_LAST  = 1'b0;
    localparam state_t RST_STATE     = IDLE;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the pointer upward, wrapping.
// The pointer moves to one past the winner only when a grant is issued while not stalled.
module rr_arbiter #(
    parameter int PORT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [PORT-1:0] req,
    output logic [PORT-1:0] granto
);

    localparam int IDX = (PORT > 1) ? $clog2(PORT) : 1;

    logic [IDX-1:0] ptr;
    logic [IDX-1:0] grant_idx;
    logic [IDX-1:0] cand_idx;
    logic           grant_any;
    int             cand;

    // Pick the first requester at or after the pointer, wrapping modulo PORT.
    always_comb begin
        granto    = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = 0; off < PORT; off++) begin
            cand = int'(ptr) + off;
            if (cand >= PORT) begin
                cand = cand - PORT;
            end
            cand_idx = IDX'(cand);
            if (!grant_any && req[cand_idx]) begin
                grant_any        = 1'b1;
                granto[cand_idx] = 1'b1;
                grant_idx        = cand_idx;
            end
        end
    end

    // Advance the priority pointer past the winner on a real, unstalled grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any && !stall) begin
            ptr <= (grant_idx == IDX'(PORT - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrated mux with a one-entry registered output stage.
// Define RR_ARB_MUX_LOCK_EN to hold the grant for whole bursts delimited by in_last;
// without it every beat is arbitrated independently and in_last only rides along.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter  int PORT = 4,
    parameter  int DATA = 32,
    localparam int IDX  = (PORT > 1) ? $clog2(PORT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PORT-1:0]      in_valid,
    output logic [PORT-1:0]      in_ready,
    input  logic [PORT*DATA-1:0] in_data,
    input  logic [PORT-1:0]      in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA-1:0]      out_data,
    output logic                 out_last,
    output logic [IDX-1:0]       out_port
);

    logic            load;
    logic            arb_stall;
    logic [PORT-1:0] grant;
    logic [PORT-1:0] sel;
    logic [PORT-1:0] xfer_vec;
    logic            xfer;
    logic [IDX-1:0]  xfer_idx;
    logic [DATA-1:0] data_arr [PORT];

    assign load = !out_valid || out_ready;

    for (genvar i = 0; i < PORT; i++) begin : g_unpack
        assign data_arr[i] = in_data[i*DATA +: DATA];
    end

    rr_arbiter #(
        .PORT (PORT)
    ) u_arbiter (
        .clk    (clk),
        .reset  (reset),
        .stall  (arb_stall),
        .req    (in_valid),
        .granto (grant)
    );

`ifdef RR_ARB_MUX_LOCK_EN
    state_t         state;
    state_t         state_nxt;
    logic [IDX-1:0] lock_idx;
    logic [IDX-1:0] lock_idx_nxt;

    // The arbiter is frozen while a burst owns the output, so its pointer only moves on fresh grants.
    assign arb_stall = !load || (state != IDLE);

    // Steer readiness to the arbiter winner when idle, or to the locked channel mid-burst.
    always_comb begin
        sel = '0;
        if (state == IDLE) begin
            sel = grant;
        end else begin
            sel[lock_idx] = 1'b1;
        end
    end

    // Enter LOCK on a non-final beat, leave it when the locked channel delivers its last beat.
    always_comb begin
        state_nxt    = state;
        lock_idx_nxt = lock_idx;
        case (state)
            IDLE: begin
                if (xfer && !in_last[xfer_idx]) begin
                    state_nxt    = LOCK;
                    lock_idx_nxt = xfer_idx;
                end
            end
            LOCK: begin
                if (xfer && in_last[xfer_idx]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Burst-lock state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RST_STATE;
            lock_idx <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_idx_nxt;
        end
    end
`else
    assign arb_stall = !load;
    assign sel       = grant;
`endif

    assign in_ready = {PORT{load && !reset}} & sel;
    assign xfer_vec = in_valid & in_ready;
    assign xfer     = |xfer_vec;

    // Encode the (at most one-hot) transfer vector into the source channel index.
    always_comb begin
        xfer_idx = '0;
        for (int i = 0; i < PORT; i++) begin
            if (xfer_vec[i]) begin
                xfer_idx = IDX'(i);
            end
        end
    end

    // Output register: load on a transfer, otherwise drop valid once downstream takes the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= RST_OUT_VALID;
            out_data  <= '0;
            out_last  <= RST_OUT_LAST;
            out_port  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[xfer_idx];
            out_last  <= in_last[xfer_idx];
            out_port  <= xfer_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

N:1 round-robin arbitrated multiplexer with valid/ready handshake on every input channel and a one-entry registered output stage. It sits directly downstream of `rr_arbiter` and consumes its one-hot grant to steer the winning channel's beat into the output register. Multi-beat bursts delimited by `last` hold the grant until the burst completes. Typical uses: merging request streams from several masters onto one shared bus or port.

## Interface
- `PORT`, 4: number of input channels, ≥1; need not be a power of two.
- `DATA`, 32: payload width per beat.
- `IDX`, `$clog2(PORT)`: constant; width of the port index (minimum 1).
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input PORT: per-channel beat valid.
- `in_ready` output PORT: per-channel accept; at most one bit set per cycle.
- `in_data` input PORT*DATA: flattened payloads; channel i occupies bits `[i*DATA +: DATA]`.
- `in_last` input PORT: final beat of a burst on channel i.
- `out_valid` output 1: output register holds a beat.
- `out_ready` input 1: downstream accept.
- `out_data` output DATA: registered payload.
- `out_last` output 1: registered last flag.
- `out_port` output IDX: index of the source channel of the held beat.

## Operation
- `load = !out_valid || out_ready`: the output register can take a new beat this cycle.
- The arbiter is driven with `req = in_valid` (IDLE state), `stall = !load || state != IDLE`. Its pointer advances only on an actual grant.
- `in_ready[i] = load && sel[i] && !reset`.
  - In IDLE, `sel` is the arbiter grant.
  - In LOCK, `sel` is the one-hot of `lock_idx`.
- Transfer on channel i: `in_valid[i] && in_ready[i]`. On a transfer, the output register loads `in_data[i]`, `in_last[i]`, `out_port = i`, and sets `out_valid = 1`.
- When `out_valid && out_ready` with no new transfer, `out_valid` clears. Data, last and port hold their old values.
- FSM (compiled only with `RR_ARB_MUX_LOCK_EN`):
  - IDLE → LOCK on a transfer with `in_last = 0`. `lock_idx` ← granted index.
  - LOCK → IDLE on a transfer from `lock_idx` with `in_last = 1`.
  - In LOCK, other channels receive no ready, even if `lock_idx` drops `in_valid`. Those cycles are bubbles; the lock is not released.
  - A single-beat burst (`in_last = 1` in IDLE) stays in IDLE.
- Priority after reset: port 0 first. After granting port k, the search starts at k+1, wrapping modulo PORT.
- `in_ready` may depend combinationally on `in_valid`. `in_valid` must not depend on `in_ready`.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `out_port` 0, state IDLE, `lock_idx` 0, arbiter pointer 0. `in_ready` is all 0 while `reset` is high.
- Latency: a beat accepted in cycle t appears on `out_*` in cycle t+1.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- Backpressure: `out_valid && !out_ready` → all `in_ready` 0, and output data, last and port are stable.
- Simultaneous drain and fill in the same cycle: the register is replaced with no bubble.
- Reset mid-burst: return to IDLE immediately. The beat in the output register is dropped. Burst integrity after reset is the upstream's responsibility.
- All PORT channels valid and contending: each channel gets exactly one grant (or one burst) per PORT grants.

## Configuration
- `RR_ARB_MUX_LOCK_EN` defined:
  - FSM and `lock_idx` present.
  - A burst is never interleaved with another channel's beats.
- Not defined:
  - No FSM; every beat is arbitrated independently.
  - `in_last` is passed through to `out_last` only.
  - The arbiter `stall = !load`.

## Structure
- Shared package `rr_arb_mux_pkg`: state enum `IDLE`/`LOCK` as a 1-bit typedef, and the reset constants.
- One sub-module: instantiate the existing `rr_arbiter` (PORT, with `reset`, `stall`, `req`, `granto`). Do not duplicate its pointer logic.
- Input unpacking and the one-hot-to-index encoder are local combinational logic.

## Test plan
- Reset, then `in_valid = 4'b1111` with all `in_last = 1` and `out_ready = 1` → `out_port` sequence 0,1,2,3,0 on cycles 1–5; `out_valid` high from cycle 1.
- Port 2 sends a 3-beat burst (`last` on beat 3) while ports 0/1/3 are valid (LOCK_EN) → three consecutive `out_port = 2` beats, then port 3 is granted.
- Port 1 mid-burst drops `in_valid` for 2 cycles (LOCK_EN) → 2 bubble cycles with `out_valid = 0` and all other `in_ready` 0; the burst then resumes on port 1.
- `out_ready = 0` for 3 cycles with `out_valid = 1`, data 0xA5A5A5A5 → `out_data` stable, `in_ready = 0`. On `out_ready = 1`, the next beat loads in the same cycle.
- `reset` asserted during a LOCK on port 3 → next cycle `out_valid = 0`, state IDLE, and port 0 is granted first.
- LOCK_EN undefined, ports 0 and 1 each stream `last = 0` beats → `out_port` alternates 0,1,0,1.
